// File: rtl/text_ram_pkg.sv
// Shared constants and FSM state type for the text buffer RAM reader and loader.
// Word geometry is fixed here so the reader and the writer agree on it.
package text_ram_pkg;

  localparam int DATA_WIDTH     = 24;
  localparam int ADDR_WIDTH     = 8;
  localparam int BYTE_WIDTH     = 8;
  localparam int BYTES_PER_WORD = DATA_WIDTH / BYTE_WIDTH;
  localparam int BYTE_CNT_WIDTH = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    SEND,
    FINISH
  } state_t;

endpackage

// File: rtl/word_unpacker.sv
// Splits one RAM word into BYTES_PER_WORD bytes, MS byte first, and presents
// them on a valid/ready stream. byte_data is taken straight from the shift register.
module word_unpacker
  import text_ram_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] word,
  input  logic                  byte_ready,
  output logic [BYTE_WIDTH-1:0] byte_data,
  output logic                  byte_valid,
  output logic                  last_byte_accepted
);

  localparam logic [BYTE_CNT_WIDTH-1:0] LAST_IDX = BYTE_CNT_WIDTH'(BYTES_PER_WORD - 1);

  logic [DATA_WIDTH-1:0]     shift_reg;
  logic [BYTE_CNT_WIDTH-1:0] byte_cnt;
  logic                      accept;

  assign accept             = byte_valid && byte_ready;
  assign last_byte_accepted = accept && (byte_cnt == LAST_IDX);
  assign byte_data          = shift_reg[DATA_WIDTH-1 -: BYTE_WIDTH];

  // NOTE: non-blocking assignments so every flop samples pre-edge values, regardless of block order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_reg  <= '0;
      byte_cnt   <= '0;
      byte_valid <= 1'b0;
    end else if (load) begin
      shift_reg  <= word;
      byte_cnt   <= '0;
      byte_valid <= 1'b1;
    end else if (accept) begin
      shift_reg <= shift_reg << BYTE_WIDTH;
      byte_cnt  <= byte_cnt + 1'b1;
      if (byte_cnt == LAST_IDX) begin
        byte_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/text_ram_reader.sv
// Read-side controller for the text buffer RAM: reads num_words words from base_addr
// and streams them out as bytes. No prefetch; a read colliding with a write is retried.
module text_ram_reader
  import text_ram_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   num_words,
  input  logic                  ram_we,
  output logic                  ram_re,
  output logic [ADDR_WIDTH-1:0] ram_read_address,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic [BYTE_WIDTH-1:0] byte_data,
  output logic                  byte_valid,
  input  logic                  byte_ready,
  output logic                  busy,
  output logic                  done
);

  state_t                state;
  state_t                next_state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH:0]   words_left;
  logic                  load;
  logic                  last_byte_accepted;
  logic                  ram_re_next;
  logic                  busy_next;
  logic                  done_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // NOTE: assign every output a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = (num_words == '0) ? FINISH : ISSUE;
      ISSUE:   if (!ram_we) next_state = CAPTURE;
      CAPTURE: next_state = SEND;
      SEND:    if (last_byte_accepted) next_state = (words_left != '0) ? ISSUE : FINISH;
      FINISH:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are decoded from next_state and registered, so they line up with the state itself.
  always_comb begin
    ram_re_next = (next_state == ISSUE);
    busy_next   = (next_state == ISSUE) || (next_state == CAPTURE) || (next_state == SEND);
    done_next   = (next_state == FINISH);
    load        = (state == CAPTURE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ram_re <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      ram_re <= ram_re_next;
      busy   <= busy_next;
      done   <= done_next;
    end
  end

  // Address wraps naturally at 2^ADDR_WIDTH, so a full 256-word job visits every word once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr       <= '0;
      words_left <= '0;
    end else if ((state == IDLE) && start) begin
      addr       <= base_addr;
      words_left <= num_words;
    end else if (state == CAPTURE) begin
      addr       <= addr + 1'b1;
      words_left <= words_left - 1'b1;
    end
  end

  assign ram_read_address = addr;

  word_unpacker u_word_unpacker (
    .clk                (clk),
    .reset_n            (reset_n),
    .load               (load),
    .word               (ram_q),
    .byte_ready         (byte_ready),
    .byte_data          (byte_data),
    .byte_valid         (byte_valid),
    .last_byte_accepted (last_byte_accepted)
  );

endmodule
